// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the memory controller among LSB, IF and optional PF (MEM_ARB_PREFETCH_EN).
// Grant one cycle after request; dn_* held until dn_commit; one GAP cycle after each completion or roll.
module mem_arbiter #(
  parameter int AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        roll,
  input  logic        io_buffer_full,
  input  logic        lsb_flag,
  input  logic        lsb_type,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_data,
  output logic        lsb_commit,
  output logic [31:0] lsb_val,
  input  logic        if_flag,
  input  logic [31:0] if_addr,
  output logic        if_commit,
  output logic [31:0] if_data,
  input  logic        pf_flag,
  input  logic [31:0] pf_addr,
  output logic        pf_commit,
  output logic [31:0] pf_data,
  output logic        dn_flag,
  output logic        dn_type,
  output logic [31:0] dn_addr,
  output logic [2:0]  dn_len,
  output logic [31:0] dn_data,
  input  logic        dn_commit,
  input  logic [31:0] dn_val
);
  localparam int AW = $clog2(AGE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  typedef enum logic [1:0] {OWN_LSB, OWN_IF, OWN_PF} owner_t;

  state_t        state;
  owner_t        owner;
  logic [AW-1:0] age;

  logic lsb_ok, if_ok, pf_ok, if_force, store_busy;

  // IO space (addr[17:16]==3) cannot be issued while the IO buffer is full
  assign lsb_ok     = lsb_flag && !((lsb_addr[17:16] == 2'b11) && io_buffer_full);
  assign if_ok      = if_flag;
  assign if_force   = if_ok && (age == AW'(AGE_MAX));
  assign store_busy = (owner == OWN_LSB) && dn_type;

`ifdef MEM_ARB_PREFETCH_EN
  assign pf_ok = pf_flag;
`else
  logic pf_unused;
  assign pf_unused = ^{pf_flag, pf_addr};
  assign pf_ok     = 1'b0;
  assign pf_commit = 1'b0;
  assign pf_data   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_LSB;
      age        <= '0;
      dn_flag    <= 1'b0;
      dn_type    <= 1'b0;
      dn_addr    <= '0;
      dn_len     <= '0;
      dn_data    <= '0;
      lsb_commit <= 1'b0;
      lsb_val    <= '0;
      if_commit  <= 1'b0;
      if_data    <= '0;
`ifdef MEM_ARB_PREFETCH_EN
      pf_commit  <= 1'b0;
      pf_data    <= '0;
`endif
    end else begin
      lsb_commit <= 1'b0;
      if_commit  <= 1'b0;
`ifdef MEM_ARB_PREFETCH_EN
      pf_commit  <= 1'b0;
`endif
      if (rdy) begin
        case (state)
          IDLE: begin
            age <= '0;
            if (roll) begin
              state <= GAP;
            end else if (if_force || (if_ok && !lsb_ok)) begin
              state   <= BUSY;
              owner   <= OWN_IF;
              dn_flag <= 1'b1;
              dn_type <= 1'b0;
              dn_addr <= if_addr;
              dn_len  <= 3'd4;
              dn_data <= '0;
            end else if (lsb_ok) begin
              state   <= BUSY;
              owner   <= OWN_LSB;
              dn_flag <= 1'b1;
              dn_type <= lsb_type;
              dn_addr <= lsb_addr;
              dn_len  <= lsb_len;
              dn_data <= lsb_data;
              if (if_flag)
                age <= (age == AW'(AGE_MAX)) ? age : age + AW'(1);
            end else if (pf_ok) begin
              state   <= BUSY;
              owner   <= OWN_PF;
              dn_flag <= 1'b1;
              dn_type <= 1'b0;
              dn_addr <= pf_addr;
              dn_len  <= 3'd4;
              dn_data <= '0;
            end
          end
          BUSY: begin
            if (roll)
              age <= '0;
            // a roll cancels speculative reads; an issued store must still complete
            if (roll && !store_busy) begin
              dn_flag <= 1'b0;
              state   <= GAP;
            end else if (dn_commit) begin
              dn_flag <= 1'b0;
              state   <= GAP;
              case (owner)
                OWN_IF: begin
                  if_commit <= 1'b1;
                  if_data   <= dn_val;
                end
`ifdef MEM_ARB_PREFETCH_EN
                OWN_PF: begin
                  pf_commit <= 1'b1;
                  pf_data   <= dn_val;
                end
`endif
                default: begin
                  lsb_commit <= 1'b1;
                  lsb_val    <= dn_val;
                end
              endcase
            end
          end
          GAP: begin
            if (roll)
              age <= '0;
            state <= roll ? GAP : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a simple controller model, and a monitor checking grants and commits.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, roll = 1'b0, io_buffer_full = 1'b0;
  logic        lsb_flag = 1'b0, lsb_type = 1'b0;
  logic [31:0] lsb_addr = '0, lsb_data = '0;
  logic [2:0]  lsb_len = '0;
  logic        lsb_commit;
  logic [31:0] lsb_val;
  logic        if_flag = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_commit;
  logic [31:0] if_data;
  logic        pf_flag = 1'b0;
  logic [31:0] pf_addr = '0;
  logic        pf_commit;
  logic [31:0] pf_data;
  logic        dn_flag, dn_type;
  logic [31:0] dn_addr, dn_data;
  logic [2:0]  dn_len;
  logic        dn_commit;
  logic [31:0] dn_val;

  logic        ctl_auto = 1'b1, auto_commit = 1'b0, man_commit = 1'b0;
  logic [31:0] auto_val = '0, man_val = '0;
  assign dn_commit = auto_commit | man_commit;
  assign dn_val    = auto_commit ? auto_val : man_val;

  int tests = 0;
  int fails = 0;

  typedef struct packed {logic t; logic [31:0] a; logic [2:0] l; logic [31:0] d;} gexp_t;
  typedef struct packed {logic [1:0] who; logic [31:0] d;} cexp_t;
  gexp_t gq[$];
  cexp_t cq[$];

  always #5 clk = ~clk;

  mem_arbiter #(.AGE_MAX(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .roll(roll), .io_buffer_full(io_buffer_full),
    .lsb_flag(lsb_flag), .lsb_type(lsb_type), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_data(lsb_data), .lsb_commit(lsb_commit), .lsb_val(lsb_val),
    .if_flag(if_flag), .if_addr(if_addr), .if_commit(if_commit), .if_data(if_data),
    .pf_flag(pf_flag), .pf_addr(pf_addr), .pf_commit(pf_commit), .pf_data(pf_data),
    .dn_flag(dn_flag), .dn_type(dn_type), .dn_addr(dn_addr), .dn_len(dn_len),
    .dn_data(dn_data), .dn_commit(dn_commit), .dn_val(dn_val)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00500513 : (a ^ 32'hC0DE0000);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_g(input logic t, input logic [31:0] a, input logic [2:0] l, input logic [31:0] d);
    gq.push_back({t, a, l, d});
  endtask

  task automatic push_c(input logic [1:0] who, input logic [31:0] d);
    cq.push_back({who, d});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    chk(name, 128'(gq.size() + cq.size()), 128'(0));
  endtask

  task automatic wait_grant(input int max_cyc, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = dn_flag;
    end
    chk(name, 128'(seen), 128'(1));
  endtask

  task automatic wait_commits(input int n, input int max_cyc);
    int seen = 0;
    for (int i = 0; i < max_cyc && seen < n; i++) begin
      @(negedge clk);
      if (lsb_commit || if_commit || pf_commit) seen++;
    end
    chk("commit_count", 128'(seen), 128'(n));
  endtask

  // Controller model: commits one cycle after dn_flag is seen, returning mem(dn_addr)
  task automatic ctl();
    forever begin
      @(posedge clk);
      #1;
      if (auto_commit) auto_commit = 1'b0;
      else if (ctl_auto && dn_flag && !rst) begin
        auto_val    = mem(dn_addr);
        auto_commit = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    logic  prev = 1'b0;
    gexp_t g;
    cexp_t c;
    logic [1:0] who;
    forever begin
      @(negedge clk);
      if (dn_flag && !prev) begin
        if (gq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant: got addr %0h expected no grant", dn_addr);
        end else begin
          g = gq.pop_front();
          chk("grant", 128'({dn_type, dn_addr, dn_len, dn_data}), 128'(g));
        end
      end
      prev = dn_flag;
      if (lsb_commit || if_commit || pf_commit) begin
        who = lsb_commit ? 2'd0 : (if_commit ? 2'd1 : 2'd2);
        if ($countones({lsb_commit, if_commit, pf_commit}) > 1) begin
          tests++; fails++;
          $display("FAIL multi_commit: got %b expected one-hot", {lsb_commit, if_commit, pf_commit});
        end else if (cq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_commit: got owner %0d expected none", who);
        end else begin
          c = cq.pop_front();
          chk("commit", 128'({who, who == 2'd0 ? lsb_val : (who == 2'd1 ? if_data : pf_data)}), 128'(c));
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
      ctl();
    join_none

    // Reset state
    cyc(2);
    chk("rst_dn", 128'({dn_flag, dn_type, dn_addr, dn_len, dn_data}), 128'(0));
    chk("rst_commits", 128'({lsb_commit, if_commit, pf_commit}), 128'(0));
    chk("rst_data", 128'({lsb_val, if_data, pf_data}), 128'(0));
    rst = 1'b0;
    cyc(1);

    // IF alone at address 0
    push_g(1'b0, 32'h0, 3'd4, 32'h0);
    push_c(2'd1, 32'h00500513);
    if_flag = 1'b1; if_addr = 32'h0;
    wait_grant(1, "if_grant_latency");
    wait_commits(1, 5);
    if_flag = 1'b0;
    chk("if_gap_dn_flag", 128'(dn_flag), 128'(0));
    @(negedge clk);
    chk("if_commit_single", 128'(if_commit), 128'(0));
    cyc(2); drain("t1_drain");

    // Aging: LSB x4 then IF, twice
    lsb_flag = 1'b1; lsb_type = 1'b0; lsb_addr = 32'h1000; lsb_len = 3'd4; lsb_data = 32'h0;
    if_flag = 1'b1; if_addr = 32'h2000;
    repeat (2) begin
      repeat (4) begin
        push_g(1'b0, 32'h1000, 3'd4, 32'h0);
        push_c(2'd0, 32'hC0DE1000);
      end
      push_g(1'b0, 32'h2000, 3'd4, 32'h0);
      push_c(2'd1, 32'hC0DE2000);
    end
    wait_commits(10, 60);
    lsb_flag = 1'b0; if_flag = 1'b0;
    cyc(3); drain("age_drain");

    // IO store blocked while buffer full
    lsb_flag = 1'b1; lsb_type = 1'b1; lsb_addr = 32'h30000; lsb_len = 3'd4; lsb_data = 32'hDEADBEEF;
    io_buffer_full = 1'b1;
    if_flag = 1'b1; if_addr = 32'h44;
    push_g(1'b0, 32'h44, 3'd4, 32'h0);
    push_c(2'd1, 32'hC0DE0044);
    wait_commits(1, 10);
    if_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("io_blocked", 128'(dn_flag), 128'(0));
    end
    push_g(1'b1, 32'h30000, 3'd4, 32'hDEADBEEF);
    push_c(2'd0, 32'hC0DD0000);
    io_buffer_full = 1'b0;
    wait_commits(1, 10);
    lsb_flag = 1'b0;
    cyc(2); drain("io_drain");

    // Roll during IF read with simultaneous dn_commit
    ctl_auto = 1'b0;
    push_g(1'b0, 32'h80, 3'd4, 32'h0);
    if_flag = 1'b1; if_addr = 32'h80;
    wait_grant(2, "roll_if_grant");
    roll = 1'b1; man_commit = 1'b1; man_val = 32'h12345678;
    @(negedge clk);
    chk("roll_if_dn_flag", 128'(dn_flag), 128'(0));
    chk("roll_if_no_commit", 128'(if_commit), 128'(0));
    chk("roll_if_data_hold", 128'(if_data), 128'(32'hC0DE0044));
    roll = 1'b0; man_commit = 1'b0; if_addr = 32'h84; ctl_auto = 1'b1;
    push_g(1'b0, 32'h84, 3'd4, 32'h0);
    push_c(2'd1, 32'hC0DE0084);
    @(negedge clk);
    chk("roll_gap_idle", 128'(dn_flag), 128'(0));
    @(negedge clk);
    chk("roll_regrant", 128'(dn_flag), 128'(1));
    wait_commits(1, 5);
    if_flag = 1'b0;
    cyc(2); drain("roll_if_drain");

    // Roll during LSB store is ignored
    ctl_auto = 1'b0;
    push_g(1'b1, 32'h200, 3'd2, 32'h0000ABCD);
    push_c(2'd0, 32'h55AA55AA);
    lsb_flag = 1'b1; lsb_type = 1'b1; lsb_addr = 32'h200; lsb_len = 3'd2; lsb_data = 32'h0000ABCD;
    wait_grant(2, "store_grant");
    roll = 1'b1;
    @(negedge clk);
    chk("roll_store_hold", 128'(dn_flag), 128'(1));
    roll = 1'b0; man_commit = 1'b1; man_val = 32'h55AA55AA;
    @(negedge clk);
    man_commit = 1'b0;
    chk("roll_store_commit", 128'(lsb_commit), 128'(1));
    lsb_flag = 1'b0;
    cyc(2); drain("roll_store_drain");

    // Reset mid-BUSY
    push_g(1'b0, 32'h100, 3'd4, 32'h0);
    lsb_flag = 1'b1; lsb_type = 1'b0; lsb_addr = 32'h100; lsb_len = 3'd4; lsb_data = 32'h0;
    wait_grant(2, "rstb_grant");
    rst = 1'b1;
    #1;
    chk("rstb_dn", 128'({dn_flag, dn_addr, dn_len}), 128'(0));
    chk("rstb_data", 128'({lsb_val, if_data}), 128'(0));
    lsb_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstb_quiet", 128'(dn_flag), 128'(0));
    end
    ctl_auto = 1'b1;
    push_g(1'b0, 32'h100, 3'd4, 32'h0);
    push_c(2'd0, 32'hC0DE0100);
    lsb_flag = 1'b1;
    wait_commits(1, 6);
    lsb_flag = 1'b0;
    cyc(2); drain("rstb_drain");

    // rdy low freezes grant and ignores dn_commit
    ctl_auto = 1'b0; rdy = 1'b0;
    lsb_flag = 1'b1; lsb_type = 1'b0; lsb_addr = 32'h300; lsb_len = 3'd4; lsb_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rdy_frozen", 128'(dn_flag), 128'(0));
    end
    push_g(1'b0, 32'h300, 3'd4, 32'h0);
    rdy = 1'b1;
    wait_grant(1, "rdy_resume");
    rdy = 1'b0; man_commit = 1'b1; man_val = 32'h0BADF00D;
    @(negedge clk);
    chk("rdy_commit_ignored", 128'(lsb_commit), 128'(0));
    chk("rdy_busy_hold", 128'(dn_flag), 128'(1));
    push_c(2'd0, 32'h600DF00D);
    rdy = 1'b1; man_val = 32'h600DF00D;
    @(negedge clk);
    man_commit = 1'b0; lsb_flag = 1'b0;
    chk("rdy_commit", 128'(lsb_commit), 128'(1));
    ctl_auto = 1'b1;
    cyc(2); drain("rdy_drain");

    // Prefetch requester
    pf_flag = 1'b1; pf_addr = 32'h40;
`ifdef MEM_ARB_PREFETCH_EN
    push_g(1'b0, 32'h40, 3'd4, 32'h0);
    push_c(2'd2, 32'hC0DE0040);
    wait_commits(1, 6);
    pf_flag = 1'b0;
    cyc(2); drain("pf_drain");
`else
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("pf_off", 128'({dn_flag, pf_commit}), 128'(0));
    end
    pf_flag = 1'b0;
    chk("pf_data_off", 128'(pf_data), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
